icache_refill: RTL and testbench
================================

// Module: icache_refill
// PURPOSE
// - Miss-service engine that answers the icache: on cache_miss it reads one 32-bit instruction word from SPI flash.
// - Returns the word on write_data with a one-cycle fetch pulse, completing the icache's refill (write) state.
// - Sits between the icache and the board SPI flash pins (iCE40 target); standard 0x03 READ command, SPI mode 0.
// PARAMETERS
// - FLASH_BASE  24'h100000  flash byte offset of instruction image; added to miss address (24-bit wrap)
// - CLK_DIV     2           SCK half-period in CLK cycles; legal range 1..255
// PORTS
// - CLK         in   1   system clock, all logic on rising edge
// - RST         in   1   reset: synchronous, active-high
// - cache_miss  in   1   icache miss request; held high until fetch is seen
// - miss_addr   in   20  missed byte address; stable while cache_miss=1; bits [1:0] ignored
// - fetch       out  1   one-cycle pulse: write_data valid, refill complete
// - write_data  out  32  fetched word, little-endian (lowest flash byte -> [7:0])
// - busy        out  1   high from request accept until the cycle after fetch
// - spi_cs_n    out  1   flash chip select, active-low
// - spi_sck     out  1   SPI clock, idles low (mode 0)
// - spi_mosi    out  1   command/address out, MSB first, changes while SCK low
// - spi_miso    in   1   data in, sampled on SCK rising edge
// BEHAVIOUR
// - Reset: fetch=0, write_data=0, busy=0, spi_cs_n=1, spi_sck=0, spi_mosi=0; FSM -> IDLE; RST wins over every event.
// - States: IDLE -> CMD -> DATA -> RESP -> GUARD -> IDLE.
// - IDLE: cache_miss sampled 1 in cycle N -> latch flash_addr = FLASH_BASE + {4'b0, miss_addr[19:2], 2'b00} mod 2^24.
//   - Also in cycle N: busy=1, go to CMD.
// - CMD: cs_n=0 from N+1; 32 bits shifted out: 8'h03, then flash_addr[23:0].
//   - Each bit: SCK low CLK_DIV cycles (MOSI updated at start of low phase), then high CLK_DIV cycles.
// - DATA: 32 more SCK periods; MOSI held 0; MISO sampled at each rising edge.
//   - Byte k (k = 0..3, MSB first) lands in write_data[8k+7:8k].
// - RESP: cycle N+1+128*CLK_DIV: fetch=1 for exactly one cycle with final write_data; cs_n=1, sck=0 same cycle.
// - GUARD: cs_n held high 2*CLK_DIV cycles (flash deselect time); cache_miss ignored here.
//   - Also covers the icache dropping cache_miss after fetch; busy=0 on GUARD exit.
// - write_data holds last fetched word until next RESP; not cleared by new requests.
// - cache_miss dropping mid-transaction: transaction still completes and fetch still pulses (icache cannot cancel).
// - RST mid-transaction: next cycle cs_n=1, sck=0; no fetch pulse; partial data discarded.
// - Address wrap: FLASH_BASE + addr overflow wraps modulo 2^24, no error.
// - Bit/period counters: 6-bit bit counter (0..63), 8-bit divider counter; no overflow possible in legal CLK_DIV range.
// CONFIGURATION
// - Macro ICACHE_REFILL_SEQ_EN: sequential continuous read.
// - Defined:
//   - After RESP, cs_n stays 0 and sck stays 0; FSM enters OPEN (busy=0) instead of GUARD.
//   - From OPEN, a miss whose flash_addr == previous+4 skips CMD: DATA only; fetch at N+1+64*CLK_DIV.
//   - From OPEN, any other miss: cs_n=1 for 2*CLK_DIV cycles, then normal CMD.
//     - fetch at N+1+130*CLK_DIV.
//   - cache_miss is ignored in OPEN for the first cycle after RESP.
//   - RST from OPEN releases cs_n as above.
// - Undefined: OPEN state absent; every request takes the full CMD path; cs_n released after each word.
// TESTING
// - Reset: hold RST 3 cycles mid-idle -> fetch=0, busy=0, spi_cs_n=1, spi_sck=0, spi_mosi=0, write_data=0.
// - CLK_DIV=1, miss_addr=20'h00404:
//   - MOSI bytes 03 10 04 04; flash model returns 13 01 00 00.
//   - Response: fetch at N+129, write_data=32'h00000113.
// - CLK_DIV=3, any miss -> fetch exactly at N+385; SCK high/low phases each 3 cycles; single-cycle fetch pulse.
// - Back-to-back: second cache_miss asserted the cycle after fetch -> ignored through GUARD.
//   - Second cs_n falling edge no earlier than 2*CLK_DIV cycles after first cs_n rise.
// - RST asserted at bit 40 of DATA -> cs_n=1 next cycle, no fetch; a following miss completes normally with correct data.
// - SEQ_EN, CLK_DIV=1: miss 20'h00100 then 20'h00104.
//   - Second fetch at N+65, no 8'h03 on MOSI; then miss 20'h00200 -> full command, fetch at N+131.

Source files
------------

// File: rtl/icache_refill.sv
// icache_refill: instruction-cache miss service engine. On cache_miss it
// reads one 32-bit word from SPI flash using the 0x03 READ command in SPI
// mode 0. It returns the word on write_data together with a one-cycle
// fetch pulse.
//
// Ports
//   CLK, RST          system clock, synchronous active-high reset
//   cache_miss        miss request, held high by the icache until fetch
//   miss_addr[19:0]   missed byte address (bits [1:0] ignored)
//   fetch             one-cycle pulse, write_data valid
//   write_data[31:0]  fetched word, lowest flash byte in [7:0]
//   busy              request in progress (includes deselect guard)
//   spi_cs_n, spi_sck, spi_mosi, spi_miso   flash pins (mode 0)
//
// Optional feature macro: ICACHE_REFILL_SEQ_EN
//   When defined, the flash stays selected after a word. A miss at the
//   next word address continues the open read without resending the
//   command.
//
// state | meaning
// IDLE  | waiting for cache_miss
// CMD   | shifting out 0x03 + 24-bit address
// DATA  | clocking in 32 data bits
// RESP  | fetch pulse, word presented
// GUARD | flash deselect time (also re-command gap in SEQ mode)
// OPEN  | SEQ mode only: flash left selected, awaiting next miss

module icache_refill #(
  parameter logic [23:0] FLASH_BASE = 24'h100000,
  parameter int unsigned CLK_DIV    = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        cache_miss,
  input  logic [19:0] miss_addr,
  output logic        fetch,
  output logic [31:0] write_data,
  output logic        busy,
  output logic        spi_cs_n,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);
  localparam logic [7:0] CMD_READ = 8'h03;

  typedef enum logic [2:0] {IDLE, CMD, DATA, RESP, GUARD, OPEN} state_t;

  state_t      state, state_next;
  logic [7:0]  div_cnt;
  logic [5:0]  bit_cnt;
  logic [31:0] shreg;
  logic [23:0] flash_addr;
  logic [23:0] new_addr;
  logic        restart;
  logic        tick;
  logic        fall;

  assign new_addr = FLASH_BASE + {4'b0, miss_addr & 20'hFFFFC};
  assign tick     = (div_cnt == 8'd0);
  assign fall     = tick & spi_sck;

`ifdef ICACHE_REFILL_SEQ_EN
  logic open_first;
  logic seq_hit;
  assign seq_hit = (new_addr == flash_addr + 24'd4);
`endif

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (cache_miss) state_next = CMD;
      CMD:   if (fall && bit_cnt == 6'd32) state_next = DATA;
      DATA:  if (fall && bit_cnt == 6'd0) state_next = RESP;
`ifdef ICACHE_REFILL_SEQ_EN
      RESP:  state_next = OPEN;
      OPEN:  if (!open_first && cache_miss) state_next = seq_hit ? DATA : GUARD;
`else
      RESP:  state_next = GUARD;
      OPEN:  state_next = IDLE;
`endif
      GUARD: if (tick && bit_cnt == 6'd0) state_next = restart ? CMD : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      div_cnt    <= 8'd0;
      bit_cnt    <= 6'd0;
      shreg      <= 32'd0;
      flash_addr <= 24'd0;
      restart    <= 1'b0;
      fetch      <= 1'b0;
      write_data <= 32'd0;
      busy       <= 1'b0;
      spi_cs_n   <= 1'b1;
      spi_sck    <= 1'b0;
      spi_mosi   <= 1'b0;
`ifdef ICACHE_REFILL_SEQ_EN
      open_first <= 1'b0;
`endif
    end else begin
      fetch <= 1'b0;
`ifdef ICACHE_REFILL_SEQ_EN
      open_first <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (cache_miss) begin
            flash_addr <= new_addr;
            busy       <= 1'b1;
            spi_cs_n   <= 1'b0;
            spi_sck    <= 1'b0;
            spi_mosi   <= CMD_READ[7];
            div_cnt    <= DIV_LOAD;
            bit_cnt    <= 6'd63;
            shreg      <= {CMD_READ, new_addr};
          end
        end
        CMD, DATA: begin
          if (!tick) begin
            div_cnt <= div_cnt - 8'd1;
          end else begin
            div_cnt <= DIV_LOAD;
            if (!spi_sck) begin
              spi_sck <= 1'b1;
              if (state == DATA) shreg <= {shreg[30:0], spi_miso};
            end else begin
              spi_sck <= 1'b0;
              // bit_cnt==32 ends the last command bit; MOSI then idles at 0
              if (state == CMD && bit_cnt != 6'd32) begin
                shreg    <= {shreg[30:0], 1'b0};
                spi_mosi <= shreg[30];
              end else begin
                spi_mosi <= 1'b0;
              end
              if (bit_cnt == 6'd0) begin
                fetch      <= 1'b1;
                write_data <= {shreg[7:0], shreg[15:8], shreg[23:16], shreg[31:24]};
`ifndef ICACHE_REFILL_SEQ_EN
                spi_cs_n   <= 1'b1;
`endif
              end else begin
                bit_cnt <= bit_cnt - 6'd1;
              end
            end
          end
        end
        RESP: begin
`ifdef ICACHE_REFILL_SEQ_EN
          busy       <= 1'b0;
          open_first <= 1'b1;
`else
          // guard is two half-periods of CLK_DIV cycles each
          div_cnt <= DIV_LOAD;
          bit_cnt <= 6'd1;
`endif
        end
        GUARD: begin
          if (!tick) begin
            div_cnt <= div_cnt - 8'd1;
          end else if (bit_cnt != 6'd0) begin
            bit_cnt <= bit_cnt - 6'd1;
            div_cnt <= DIV_LOAD;
          end else if (restart) begin
            restart  <= 1'b0;
            spi_cs_n <= 1'b0;
            spi_sck  <= 1'b0;
            spi_mosi <= CMD_READ[7];
            div_cnt  <= DIV_LOAD;
            bit_cnt  <= 6'd63;
            shreg    <= {CMD_READ, flash_addr};
          end else begin
            busy <= 1'b0;
          end
        end
`ifdef ICACHE_REFILL_SEQ_EN
        OPEN: begin
          if (!open_first && cache_miss) begin
            flash_addr <= new_addr;
            busy       <= 1'b1;
            div_cnt    <= DIV_LOAD;
            if (seq_hit) begin
              bit_cnt <= 6'd31;
            end else begin
              spi_cs_n <= 1'b1;
              restart  <= 1'b1;
              bit_cnt  <= 6'd1;
            end
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_refill.sv
module tb_icache_refill;

  logic        CLK;
  logic        RST;

  logic        miss_a, fetch_a, busy_a, cs_a, sck_a, mosi_a, miso_a;
  logic [19:0] addr_a;
  logic [31:0] wdata_a;
  logic        miss_b, fetch_b, busy_b, cs_b, sck_b, mosi_b, miso_b;
  logic [19:0] addr_b;
  logic [31:0] wdata_b;

  int checks = 0;
  int errors = 0;

  icache_refill #(.FLASH_BASE(24'h100000), .CLK_DIV(1)) u_a (
    .CLK(CLK), .RST(RST), .cache_miss(miss_a), .miss_addr(addr_a),
    .fetch(fetch_a), .write_data(wdata_a), .busy(busy_a),
    .spi_cs_n(cs_a), .spi_sck(sck_a), .spi_mosi(mosi_a), .spi_miso(miso_a)
  );

  icache_refill #(.FLASH_BASE(24'hFF0000), .CLK_DIV(3)) u_b (
    .CLK(CLK), .RST(RST), .cache_miss(miss_b), .miss_addr(addr_b),
    .fetch(fetch_b), .write_data(wdata_b), .busy(busy_b),
    .spi_cs_n(cs_b), .spi_sck(sck_b), .spi_mosi(mosi_b), .spi_miso(miso_b)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Flash contents: a few fixed bytes, otherwise a simple address hash.
  function automatic logic [7:0] fbyte(input logic [23:0] a);
    case (a)
      24'h100404: return 8'h13;
      24'h100405: return 8'h01;
      24'h100406, 24'h100407: return 8'h00;
      default: return a[7:0] ^ a[15:8] ^ 8'h5A;
    endcase
  endfunction

  // Flash model A: captures command on SCK rise, shifts data out on SCK fall.
  logic [31:0] cmd_a = 32'd0;
  int          nb_a = 0;
  int          bi_a;
  logic [7:0]  byte_a;
  initial miso_a = 1'b0;
  always @(negedge cs_a or posedge sck_a) begin
    if (!cs_a) begin
      if (sck_a) begin
        if (nb_a < 32) cmd_a = {cmd_a[30:0], mosi_a};
        nb_a++;
      end else begin
        nb_a = 0;
      end
    end
  end
  always @(negedge sck_a) begin
    if (!cs_a && nb_a >= 32) begin
      bi_a   = nb_a - 32;
      byte_a = fbyte(cmd_a[23:0] + 24'(bi_a / 8));
      miso_a = byte_a[7 - (bi_a % 8)];
    end
  end

  logic [31:0] cmd_b = 32'd0;
  int          nb_b = 0;
  int          bi_b;
  logic [7:0]  byte_b;
  initial miso_b = 1'b0;
  always @(negedge cs_b or posedge sck_b) begin
    if (!cs_b) begin
      if (sck_b) begin
        if (nb_b < 32) cmd_b = {cmd_b[30:0], mosi_b};
        nb_b++;
      end else begin
        nb_b = 0;
      end
    end
  end
  always @(negedge sck_b) begin
    if (!cs_b && nb_b >= 32) begin
      bi_b   = nb_b - 32;
      byte_b = fbyte(cmd_b[23:0] + 24'(bi_b / 8));
      miso_b = byte_b[7 - (bi_b % 8)];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue a miss on A once idle; returns latency in cycles after the accept
  // cycle N (fetch seen in cycle N+lat). Ends at the fetch cycle's negedge.
  task automatic miss_a_run(input logic [19:0] addr, input int budget, output int lat_o);
    int w = 0;
    while (busy_a && w < 1000) begin
      @(negedge CLK);
      w++;
    end
    @(negedge CLK);
    miss_a = 1'b1;
    addr_a = addr;
    @(posedge CLK);
    lat_o = 0;
    while (lat_o < budget) begin
      @(negedge CLK);
      lat_o++;
      if (fetch_a) break;
    end
    miss_a = 1'b0;
  endtask

  int   lat, g, nf, run, pmin, pmax;
  logic prev;

  initial begin
    RST = 1'b1; miss_a = 1'b0; addr_a = 20'd0; miss_b = 1'b0; addr_b = 20'd0;
    repeat (3) @(posedge CLK);
    @(negedge CLK) RST = 1'b0;
    repeat (4) @(negedge CLK);

    // reset held 3 cycles while idle
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    chk("rst_fetch", 32'(fetch_a), 32'd0);
    chk("rst_busy",  32'(busy_a),  32'd0);
    chk("rst_cs_n",  32'(cs_a),    32'd1);
    chk("rst_sck",   32'(sck_a),   32'd0);
    chk("rst_mosi",  32'(mosi_a),  32'd0);
    chk("rst_wdata", wdata_a,      32'd0);
    chk("rst_cs_n_b", 32'(cs_b),   32'd1);
    RST = 1'b0;
    @(negedge CLK);

    // CLK_DIV=1, 0x00404 -> flash 0x100404, bytes 13 01 00 00
    miss_a_run(20'h00404, 300, lat);
    chk("a_latency", 32'(lat), 32'd129);
    chk("a_wdata",   wdata_a,  32'h00000113);
    chk("a_cmd",     cmd_a,    32'h03100404);
`ifdef ICACHE_REFILL_SEQ_EN
    chk("a_cs_at_fetch", 32'(cs_a), 32'd0);
`else
    chk("a_cs_at_fetch", 32'(cs_a), 32'd1);
`endif
    chk("a_sck_at_fetch",  32'(sck_a),  32'd0);
    chk("a_busy_at_fetch", 32'(busy_a), 32'd1);
    @(negedge CLK);
    chk("a_fetch_width", 32'(fetch_a), 32'd0);

`ifndef ICACHE_REFILL_SEQ_EN
    // back-to-back: new miss the cycle after fetch; RESP + 2 guard + accept
    miss_a = 1'b1;
    addr_a = 20'h00100;
    chk("b2b_busy_guard", 32'(busy_a), 32'd1);
    g = 1;
    while (cs_a && g < 50) begin
      @(negedge CLK);
      g++;
    end
    chk("b2b_cs_gap_ge4", 32'(g >= 4), 32'd1);
    lat = 0;
    while (!fetch_a && lat < 300) begin
      @(negedge CLK);
      lat++;
    end
    miss_a = 1'b0;
    chk("b2b_fetch", 32'(fetch_a), 32'd1);
    chk("b2b_wdata", wdata_a, 32'h58595A5B);

    // reset during DATA (bit 40 -> cycle N+81)
    g = 0;
    while (busy_a && g < 50) begin
      @(negedge CLK);
      g++;
    end
    @(negedge CLK);
    miss_a = 1'b1;
    addr_a = 20'h00404;
    @(posedge CLK);
    repeat (81) @(negedge CLK);
    chk("mid_cs_active", 32'(cs_a), 32'd0);
    RST = 1'b1;
    miss_a = 1'b0;
    @(negedge CLK);
    chk("mid_rst_cs_n",  32'(cs_a),    32'd1);
    chk("mid_rst_sck",   32'(sck_a),   32'd0);
    chk("mid_rst_fetch", 32'(fetch_a), 32'd0);
    chk("mid_rst_busy",  32'(busy_a),  32'd0);
    chk("mid_rst_wdata", wdata_a,      32'd0);
    RST = 1'b0;
    nf = 0;
    repeat (150) begin
      @(negedge CLK);
      if (fetch_a) nf++;
    end
    chk("mid_no_fetch", 32'(nf), 32'd0);
    miss_a_run(20'h00104, 300, lat);
    chk("post_rst_latency", 32'(lat), 32'd129);
    chk("post_rst_wdata", wdata_a, 32'h5C5D5E5F);
`else
    // non-sequential from OPEN: deselect gap then full command
    miss_a_run(20'h00100, 300, lat);
    chk("seq1_latency", 32'(lat), 32'd131);
    chk("seq1_cmd",     cmd_a,    32'h03100100);
    chk("seq1_wdata",   wdata_a,  32'h58595A5B);
    @(negedge CLK);
    chk("seq1_fetch_width", 32'(fetch_a), 32'd0);
    // next word: data only, no new command (flash sees 64+32 clocks)
    miss_a_run(20'h00104, 300, lat);
    chk("seq2_latency", 32'(lat), 32'd65);
    chk("seq2_wdata",   wdata_a,  32'h5C5D5E5F);
    chk("seq2_clocks",  32'(nb_a), 32'd96);
    chk("seq2_cs_held", 32'(cs_a), 32'd0);
    @(negedge CLK);
    miss_a_run(20'h00200, 300, lat);
    chk("seq3_latency", 32'(lat), 32'd131);
    chk("seq3_cmd",     cmd_a,    32'h03100200);
    chk("seq3_wdata",   wdata_a,  32'h5B5A5958);
`endif

    // CLK_DIV=3, base 0xFF0000: 0x10001 -> 0x000000 after 24-bit wrap
    @(negedge CLK);
    miss_b = 1'b1;
    addr_b = 20'h10001;
    @(posedge CLK);
    lat = 0; run = 0; prev = 1'b0; pmin = 999; pmax = 0;
    while (lat < 500) begin
      @(negedge CLK);
      lat++;
      if (sck_b == prev) begin
        run++;
      end else begin
        if (run < pmin) pmin = run;
        if (run > pmax) pmax = run;
        run = 1;
        prev = sck_b;
      end
      if (fetch_b) break;
    end
    miss_b = 1'b0;
    chk("b_latency",   32'(lat),  32'd385);
    chk("b_wdata",     wdata_b,   32'h59585B5A);
    chk("b_cmd_wrap",  cmd_b,     32'h03000000);
    chk("b_phase_min", 32'(pmin), 32'd3);
    chk("b_phase_max", 32'(pmax), 32'd3);
    @(negedge CLK);
    chk("b_fetch_width", 32'(fetch_b), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

endmodule
